// File: rtl/ask_sym_src_pkg.sv
// ask_sym_src_pkg: shared definitions for the 4-ASK symbol source and the
// PRBS15 generator (mode encodings, FSM states, Gray symbol codes, LFSR taps).
package ask_sym_src_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_PRBS  = 2'b01;
  localparam logic [1:0] MODE_IMP   = 2'b10;
  localparam logic [1:0] MODE_CONST = 2'b11;

  typedef enum logic [1:0] {
    S_OFF,
    S_PRBS,
    S_IMP,
    S_CONST
  } state_t;

  // Gray codes for the four amplitude levels; idle symbols report 00
  localparam logic [1:0] GRAY_NEG3 = 2'b00;
  localparam logic [1:0] GRAY_NEG1 = 2'b01;
  localparam logic [1:0] GRAY_POS1 = 2'b11;
  localparam logic [1:0] GRAY_POS3 = 2'b10;
  localparam logic [1:0] GRAY_IDLE = 2'b00;

  // x^15 + x^14 + 1, Fibonacci form
  localparam int unsigned PRBS_LEN   = 15;
  localparam int unsigned PRBS_TAP_A = 14;
  localparam int unsigned PRBS_TAP_B = 13;

  function automatic logic [PRBS_LEN-1:0] prbs15_step(input logic [PRBS_LEN-1:0] s);
    return {s[PRBS_LEN-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/ask_sym_src_prbs15_2step.sv
// prbs15_2step: PRBS15 generator that advances two bits per enable.
// b1/b0 show the next two output bits (b1 first) from the current state,
// so the consumer uses them in the same cycle it asserts en.
module prbs15_2step
  import ask_sym_src_pkg::*;
#(
  parameter logic [PRBS_LEN-1:0] SEED = 15'h7FFF
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic b1,
  output logic b0
);

  logic [PRBS_LEN-1:0] lfsr_q;
  logic [PRBS_LEN-1:0] lfsr_d;
  logic [PRBS_LEN-1:0] lfsr_mid;

  // Two single-bit steps per enable; seed load has priority over stepping
  always_comb begin
    lfsr_mid = prbs15_step(lfsr_q);
    b1       = lfsr_q[PRBS_TAP_A];
    b0       = lfsr_mid[PRBS_TAP_A];
    lfsr_d   = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = prbs15_step(lfsr_mid);
    end
  end

  // LFSR state register, reloads the seed on reset
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/ask_sym_src.sv
// ask_sym_src: 4-ASK / impulse / constant symbol source with upsampling to
// the sample rate, feeding the pulse-shaping filter input.
// Optional build macro ZOH_UPSAMPLE_EN: hold the symbol between boundaries
// (zero-order hold) instead of zero-stuffing.
module ask_sym_src
  import ask_sym_src_pkg::*;
#(
  parameter int                       WIDTH      = 18,
  parameter logic signed [WIDTH-1:0]  LEVEL_A    = 18'sd21845,
  parameter logic [PRBS_LEN-1:0]      LFSR_SEED  = 15'h7FFF,
  parameter int                       IMP_PERIOD = 64
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    sam_clk_en,
  input  logic                    sym_clk_en,
  input  logic [1:0]              mode,
  output logic signed [WIDTH-1:0] x_out,
  output logic                    sym_strobe,
  output logic [1:0]              sym_bits
);

  localparam int CNT_W = (IMP_PERIOD > 2) ? $clog2(IMP_PERIOD) : 1;
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic                    sb;
  logic                    prbs_b1, prbs_b0, prbs_en;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_cur;
  logic                    enter_imp;
  logic signed [WIDTH+1:0] a_ext, a3_ext;
  logic signed [WIDTH-1:0] lvl_1, lvl_3;
  logic signed [WIDTH-1:0] sym_val;
  logic [1:0]              sym_bits_val;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic                    strobe_q, strobe_d;
  logic [1:0]              bits_q, bits_d;

  assign sb      = sam_clk_en & sym_clk_en;
  assign prbs_en = sb && (state_d == S_PRBS);

  prbs15_2step #(
    .SEED(LFSR_SEED)
  ) u_prbs (
    .sys_clk(sys_clk),
    .rst    (rst),
    .load   (1'b0),
    .en     (prbs_en),
    .b1     (prbs_b1),
    .b0     (prbs_b0)
  );

  // Amplitude levels: 3a formed with two guard bits, then saturated to WIDTH
  always_comb begin
    a_ext  = {{2{LEVEL_A[WIDTH-1]}}, LEVEL_A};
    a3_ext = (a_ext <<< 1) + a_ext;
    lvl_1  = LEVEL_A;
    if (a3_ext > SMAX) begin
      lvl_3 = SMAX;
    end else if (a3_ext < SMIN) begin
      lvl_3 = SMIN;
    end else begin
      lvl_3 = a3_ext[WIDTH-1:0];
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: mode is sampled only at a symbol boundary
  always_comb begin
    state_d = state_q;
    if (sb) begin
      case (mode)
        MODE_OFF:   state_d = S_OFF;
        MODE_PRBS:  state_d = S_PRBS;
        MODE_IMP:   state_d = S_IMP;
        MODE_CONST: state_d = S_CONST;
        default:    state_d = S_OFF;
      endcase
    end
  end

  // Symbol value and Gray bits; decoded from state_d so the symbol at the
  // boundary where the mode changes already follows the new mode
  always_comb begin
    enter_imp    = (state_d == S_IMP) && (state_q != S_IMP);
    cnt_cur      = enter_imp ? '0 : cnt_q;
    sym_val      = '0;
    sym_bits_val = GRAY_IDLE;
    case (state_d)
      S_PRBS: begin
        sym_bits_val = {prbs_b1, prbs_b0};
        case ({prbs_b1, prbs_b0})
          GRAY_NEG3: sym_val = -lvl_3;
          GRAY_NEG1: sym_val = -lvl_1;
          GRAY_POS1: sym_val = lvl_1;
          default:   sym_val = lvl_3;
        endcase
      end
      S_IMP: begin
        if (cnt_cur == '0) begin
          sym_val      = lvl_3;
          sym_bits_val = GRAY_POS3;
        end
      end
      S_CONST: begin
        sym_val      = lvl_3;
        sym_bits_val = GRAY_POS3;
      end
      default: begin
        sym_val      = '0;
        sym_bits_val = GRAY_IDLE;
      end
    endcase
  end

  // Upsampling datapath and impulse counter next values
  always_comb begin
    x_d      = x_q;
    strobe_d = sb;
    bits_d   = bits_q;
    cnt_d    = cnt_q;
    if (sb) begin
      x_d    = sym_val;
      bits_d = sym_bits_val;
      if (state_d == S_IMP) begin
        cnt_d = (cnt_cur == CNT_W'(IMP_PERIOD - 1)) ? '0 : cnt_cur + CNT_W'(1);
      end
    end else if (sam_clk_en) begin
`ifdef ZOH_UPSAMPLE_EN
      x_d = x_q;
`else
      x_d = '0;
`endif
    end
  end

  // Output and counter registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      x_q      <= '0;
      strobe_q <= 1'b0;
      bits_q   <= '0;
      cnt_q    <= '0;
    end else begin
      x_q      <= x_d;
      strobe_q <= strobe_d;
      bits_q   <= bits_d;
      cnt_q    <= cnt_d;
    end
  end

  assign x_out      = x_q;
  assign sym_strobe = strobe_q;
  assign sym_bits   = bits_q;

endmodule

// File: tb/tb_ask_sym_src.sv
// tb_ask_sym_src: directed scoreboard bench for ask_sym_src.
module tb_ask_sym_src;

  logic               sys_clk;
  logic               rst;
  logic               sam_clk_en;
  logic               sym_clk_en;
  logic [1:0]         mode;
  logic signed [17:0] x_out;
  logic               sym_strobe;
  logic [1:0]         sym_bits;

  typedef struct packed {
    logic signed [17:0] x;
    logic [1:0]         bits;
    logic               stb;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int                 m_state;
  logic [14:0]        m_lfsr;
  int                 m_cnt;
  logic signed [17:0] m_x;
  logic [1:0]         m_bits;
  logic               m_stb;

  logic signed [17:0] sb_x;
  logic [1:0]         sb_bits;

  ask_sym_src dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .sam_clk_en(sam_clk_en),
    .sym_clk_en(sym_clk_en),
    .mode      (mode),
    .x_out     (x_out),
    .sym_strobe(sym_strobe),
    .sym_bits  (sym_bits)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic signed [17:0] lvl(input logic [1:0] g);
    case (g)
      2'b00:   return -18'sd65535;
      2'b01:   return -18'sd21845;
      2'b11:   return 18'sd21845;
      default: return 18'sd65535;
    endcase
  endfunction

  function automatic logic next_bit(inout logic [14:0] s);
    logic b;
    b = s[14];
    s = {s[13:0], s[14] ^ s[13]};
    return b;
  endfunction

  task automatic check_val(input string tag, input logic signed [17:0] got,
                           input logic signed [17:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sys_clk cycle: drive enables, predict, then compare after the edge
  task automatic tick(input logic sam, input logic sym);
    exp_t e;
    exp_t got_e;
    logic [1:0] g;
    @(negedge sys_clk);
    sam_clk_en = sam;
    sym_clk_en = sym;
    if (rst) begin
      m_state = 0;
      m_lfsr  = 15'h7FFF;
      m_cnt   = 0;
      m_x     = '0;
      m_bits  = 2'b00;
      m_stb   = 1'b0;
    end else begin
      m_stb = 1'b0;
      if (sam && sym) begin
        if (mode == 2'b10 && m_state != 2) m_cnt = 0;
        m_state = int'(mode);
        case (m_state)
          1: begin
            g[1]   = next_bit(m_lfsr);
            g[0]   = next_bit(m_lfsr);
            m_bits = g;
            m_x    = lvl(g);
          end
          2: begin
            if (m_cnt == 0) begin
              m_x = 18'sd65535; m_bits = 2'b10;
            end else begin
              m_x = '0; m_bits = 2'b00;
            end
            m_cnt = (m_cnt + 1) % 64;
          end
          3: begin
            m_x = 18'sd65535; m_bits = 2'b10;
          end
          default: begin
            m_x = '0; m_bits = 2'b00;
          end
        endcase
        m_stb = 1'b1;
      end else if (sam) begin
`ifndef ZOH_UPSAMPLE_EN
        m_x = '0;
`endif
      end
    end
    e.x = m_x; e.bits = m_bits; e.stb = m_stb;
    q.push_back(e);
    @(posedge sys_clk);
    #1;
    got_e = q.pop_front();
    checks++;
    assert (x_out === got_e.x)
    else begin
      errors++;
      $error("FAIL x_out got %0d expected %0d at %0t", x_out, got_e.x, $time);
    end
    checks++;
    assert (sym_bits === got_e.bits)
    else begin
      errors++;
      $error("FAIL sym_bits got %b expected %b at %0t", sym_bits, got_e.bits, $time);
    end
    checks++;
    assert (sym_strobe === got_e.stb)
    else begin
      errors++;
      $error("FAIL sym_strobe got %b expected %b at %0t", sym_strobe, got_e.stb, $time);
    end
  endtask

  // One symbol of n samples, each sample followed by an idle cycle
  task automatic symbol(input int n);
    tick(1'b1, 1'b1);
    sb_x    = x_out;
    sb_bits = sym_bits;
    tick(1'b0, 1'b0);
    for (int k = 1; k < n; k++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    logic signed [17:0] first_x[8];
    logic [1:0]         first_b[8];
    for (int i = 0; i < 7; i++) begin
      first_x[i] = 18'sd21845; first_b[i] = 2'b11;
    end
    first_x[7] = 18'sd65535; first_b[7] = 2'b10;

    rst = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0; mode = 2'b00;
    m_state = 0; m_lfsr = 15'h7FFF; m_cnt = 0; m_x = '0; m_bits = 2'b00; m_stb = 1'b0;

    // reset, including reset overriding a boundary
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check_val("reset_x", x_out, 18'sd0);
    rst = 1'b0;

    // PRBS start from seed: 7 x +a then +3a
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      symbol(4);
      check_val("prbs_first_x", sb_x, first_x[i]);
      check_val("prbs_first_bits", 18'(sb_bits), 18'(first_b[i]));
    end
    for (int i = 8; i < 20; i++) symbol(2);

    // reset mid-symbol with enables active
    tick(1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b1);
    check_val("rst_mid_x", x_out, 18'sd0);
    rst = 1'b0;
    symbol(2);
    check_val("restart_x", sb_x, 18'sd21845);
    check_val("restart_bits", 18'(sb_bits), 18'(2'b11));
    symbol(2);

    // mode change between boundaries waits for the next boundary
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    mode = 2'b10;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    symbol(2);
    check_val("mode_chg_impulse", sb_x, 18'sd65535);

    // impulse train over 130 symbols from a fresh entry
    mode = 2'b00;
    symbol(2);
    mode = 2'b10;
    for (int i = 0; i < 130; i++) begin
      symbol(2);
      check_val("impulse_x", sb_x, (i % 64 == 0) ? 18'sd65535 : 18'sd0);
    end

    // constant mode
    mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      symbol(2);
      check_val("const_x", sb_x, 18'sd65535);
    end

    // off freezes the LFSR; PRBS resumes where it stopped
    mode = 2'b01;
    for (int i = 0; i < 5; i++) symbol(2);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      symbol(2);
      check_val("off_x", sb_x, 18'sd0);
    end
    mode = 2'b01;
    for (int i = 0; i < 10; i++) symbol(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ask_sym_src.md
Name: ask_sym_src

Overview:
- Transmit-side source stage feeding the pulse-shaping filter's 18-bit x_in.
- Generates 4-ASK symbols from a PRBS15 generator, or a periodic impulse for measuring the filter's impulse response.
- Upsamples symbols to the sample rate (zero-stuffing) using the clk_en enables sam_clk_en/sym_clk_en.
- Replaces file-driven stimulus so the filter chain runs standalone in hardware.

Parameters:
- WIDTH, 18, output sample width, signed 1s17.
- LEVEL_A, 18'sd21845, unit amplitude a; levels are ±a, ±3a (3a = 65535 ≈ 0.5 FS).
- LFSR_SEED, 15'h7FFF, PRBS15 reset/reload state; must be non-zero.
- IMP_PERIOD, 64, symbols per impulse repetition; must be ≥2.

Ports:
- sys_clk  in  1  system clock
- rst  in  1  reset
- sam_clk_en  in  1  sample-rate enable, one sys_clk wide
- sym_clk_en  in  1  symbol-rate enable; coincides with a sam_clk_en
- mode  in  2  00 OFF, 01 PRBS, 10 IMPULSE, 11 CONST (+3a every symbol)
- x_out  out  WIDTH  signed sample to filter x_in
- sym_strobe  out  1  one-cycle pulse when a new symbol is placed on x_out
- sym_bits  out  2  Gray bits of current symbol (BER reference)

Interface decision: reset rst, synchronous, active-high; clock sys_clk.

Behaviour:
- Reset (rst=1 at posedge sys_clk):
  - x_out=0, sym_strobe=0, sym_bits=00.
  - LFSR=LFSR_SEED, impulse counter=0, state=S_OFF.
  - Reset overrides all enables; asserting rst mid-symbol aborts immediately.
- Symbol boundary (sb) = sam_clk_en & sym_clk_en. sym_clk_en without sam_clk_en is ignored.
- FSM states S_OFF, S_PRBS, S_IMP, S_CONST:
  - mode is sampled only at sb; the state changes at that sb, and that symbol already uses the new mode.
  - A mode change between boundaries has no effect until the next sb.
  - Entering S_IMP clears the impulse counter.
- PRBS15 (x^15+x^14+1, Fibonacci):
  - Output bit = s[14]; feedback = s[14]^s[13]; s <= {s[13:0], fb}.
  - Two steps per sb in S_PRBS only: first bit → b1, second → b0.
  - The LFSR holds its value in other states.
- Gray map: 00→-3a, 01→-a, 11→+a, 10→+3a. Arithmetic 3a = (a<<1)+a in WIDTH+2 bits, saturated to WIDTH.
- S_IMP:
  - At counter==0: symbol = +3a, sym_bits=10.
  - Other counts: symbol 0, sym_bits=00.
  - Counter increments per sb and wraps at IMP_PERIOD-1 → 0.
- S_CONST: +3a, bits 10. S_OFF: 0, bits 00.
- Upsampling:
  - At sb: x_out <= symbol, sym_strobe <= 1 for exactly one cycle.
  - At sam_clk_en without sym_clk_en: x_out <= 0 (zero-stuff).
  - Otherwise x_out holds.
  - Latency: x_out valid the cycle after the enabling edge, stable until the next sam_clk_en.
- sym_bits updates only at sb and holds between boundaries.

Optional Feature:
- Macro ZOH_UPSAMPLE_EN.
- Defined: no zero-stuffing; x_out holds the symbol value between boundaries (NRZ / zero-order hold), so the filter sees a rectangular pulse.
- Undefined: zero-stuffing as above.
- Reset, sym_strobe and sym_bits are identical in both builds.

Decomposition:
- Shared package:
  - mode encodings (MODE_OFF/PRBS/IMP/CONST);
  - FSM state typedef;
  - Gray-map constants;
  - PRBS15 tap positions.
- One sub-module prbs15_2step: LFSR with seed load, enable, and two bits per enable.
  - Reused later by the receive-side BER checker.

Test Plan:
- Reset then mode=01; the first 8 sb give x_out = +a×7 (21845), then +3a (65535). sym_bits = 11×7 then 10.
- mode=01, 4 sam_clk_en per sym_clk_en → x_out pattern sym,0,0,0 each symbol; sym_strobe high exactly one cycle per sb. With ZOH_UPSAMPLE_EN: sym,sym,sym,sym.
- mode=10 for 130 symbols → x_out=65535 at symbols 0, 64, 128; 0 at every other sample.
- Change mode 01→10 two sam_clk_en after an sb → no change until the next sb; the impulse appears at that sb.
- rst pulsed mid-PRBS at symbol 20 → next cycle x_out=0; after release the sequence restarts at symbol 1 (+a).
- mode=11 → constant 65535 at every sb; mode=00 → x_out=0 and the LFSR is frozen (resuming 01 continues the sequence, not a restart).
